// File: rtl/bram_arbiter_pkg.sv
// Shared types for bram_arbiter: FSM state encoding, requester select, address width.
// Used by both round-robin and fixed-priority (BRAM_ARBITER_FIXED_PRIORITY_EN) builds.
package bram_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_sel_t;

   function automatic port_sel_t other_port(input port_sel_t p);
      return (p == PORT_A) ? PORT_B : PORT_A;
   endfunction

endpackage

// File: rtl/bram_arbiter_rr_grant2.sv
// rr_grant2: combinational 2-way round-robin grant; the pointer only matters on a tie.
// Instantiated by bram_arbiter unless BRAM_ARBITER_FIXED_PRIORITY_EN is defined.
module rr_grant2
   import bram_arbiter_pkg::*;
(
   input  logic      i_a_request,
   input  logic      i_b_request,
   input  port_sel_t i_pointer,
   output port_sel_t o_grant,
   output logic      o_any
);

   always_comb begin
      o_any = i_a_request | i_b_request;
      if (i_a_request && i_b_request) begin
         o_grant = i_pointer;
      end else if (i_a_request) begin
         o_grant = PORT_A;
      end else begin
         o_grant = PORT_B;
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one BRAM port between requesters A and B (IDLE -> ACCESS -> RELEASE).
// Define BRAM_ARBITER_FIXED_PRIORITY_EN for A-over-B priority; default is round-robin.
module bram_arbiter
   import bram_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              i_clock,
   input  logic              i_reset_n,

   input  logic              i_a_request,
   input  logic              i_a_rw,
   input  logic [ADDR_W-1:0] i_a_address,
   input  logic [WIDTH-1:0]  i_a_wdata,
   output logic [WIDTH-1:0]  o_a_rdata,
   output logic              o_a_ready,
   output logic              o_a_valid,

   input  logic              i_b_request,
   input  logic              i_b_rw,
   input  logic [ADDR_W-1:0] i_b_address,
   input  logic [WIDTH-1:0]  i_b_wdata,
   output logic [WIDTH-1:0]  o_b_rdata,
   output logic              o_b_ready,
   output logic              o_b_valid,

   output logic              o_bram_request,
   output logic              o_bram_rw,
   output logic [ADDR_W-1:0] o_bram_address,
   output logic [WIDTH-1:0]  o_bram_wdata,
   input  logic [WIDTH-1:0]  i_bram_rdata,
   input  logic              i_bram_ready,
   input  logic              i_bram_valid
);

   state_t            r_state;
   port_sel_t         r_sel;
   logic              r_rw;
   logic [ADDR_W-1:0] r_address;
   logic [WIDTH-1:0]  r_wdata;
   logic              r_bram_request;
   logic [WIDTH-1:0]  r_a_rdata;
   logic [WIDTH-1:0]  r_b_rdata;
   logic              r_a_ready;
   logic              r_b_ready;
   logic              r_a_valid;
   logic              r_b_valid;

   port_sel_t         w_grant;
   logic              w_any_request;
   logic              w_grant_rw;
   logic [ADDR_W-1:0] w_grant_address;
   logic [WIDTH-1:0]  w_grant_wdata;
   logic              w_sel_request;

`ifdef BRAM_ARBITER_FIXED_PRIORITY_EN
   assign w_any_request = i_a_request | i_b_request;
   assign w_grant       = i_a_request ? PORT_A : PORT_B;
`else
   port_sel_t r_pointer;

   rr_grant2 u_rr_grant2 (
      .i_a_request (i_a_request),
      .i_b_request (i_b_request),
      .i_pointer   (r_pointer),
      .o_grant     (w_grant),
      .o_any       (w_any_request)
   );

   // Pointer flips to the loser of every grant so a tie alternates.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pointer <= PORT_A;
      end else if (r_state == IDLE && w_any_request) begin
         r_pointer <= other_port(w_grant);
      end
   end
`endif

   always_comb begin
      w_grant_rw      = i_a_rw;
      w_grant_address = i_a_address;
      w_grant_wdata   = i_a_wdata;
      if (w_grant == PORT_B) begin
         w_grant_rw      = i_b_rw;
         w_grant_address = i_b_address;
         w_grant_wdata   = i_b_wdata;
      end
   end

   assign w_sel_request = (r_sel == PORT_A) ? i_a_request : i_b_request;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state        <= IDLE;
         r_sel          <= PORT_A;
         r_rw           <= 1'b0;
         r_address      <= '0;
         r_wdata        <= '0;
         r_bram_request <= 1'b0;
         r_a_rdata      <= '0;
         r_b_rdata      <= '0;
         r_a_ready      <= 1'b0;
         r_b_ready      <= 1'b0;
         r_a_valid      <= 1'b0;
         r_b_valid      <= 1'b0;
      end else begin
         r_a_ready <= 1'b0;
         r_b_ready <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_request) begin
                  r_sel          <= w_grant;
                  r_rw           <= w_grant_rw;
                  r_address      <= w_grant_address;
                  r_wdata        <= w_grant_wdata;
                  r_bram_request <= 1'b1;
                  r_state        <= ACCESS;
               end
            end
            ACCESS: begin
               if (i_bram_ready) begin
                  r_bram_request <= 1'b0;
                  if (r_sel == PORT_A) begin
                     r_a_ready <= 1'b1;
                     r_a_valid <= i_bram_valid;
                     if (!r_rw) r_a_rdata <= i_bram_rdata;
                  end else begin
                     r_b_ready <= 1'b1;
                     r_b_valid <= i_bram_valid;
                     if (!r_rw) r_b_rdata <= i_bram_rdata;
                  end
                  r_state <= RELEASE;
               end
            end
            RELEASE: begin
               // Trailing memory ready lands here and is deliberately ignored.
               if (!w_sel_request) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_a_rdata      = r_a_rdata;
   assign o_a_ready      = r_a_ready;
   assign o_a_valid      = r_a_valid;
   assign o_b_rdata      = r_b_rdata;
   assign o_b_ready      = r_b_ready;
   assign o_b_valid      = r_b_valid;
   assign o_bram_request = r_bram_request;
   assign o_bram_rw      = r_rw;
   assign o_bram_address = r_address;
   assign o_bram_wdata   = r_wdata;

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data width of both requester ports and the memory port.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Port: i_clock  in  1  system clock; all state changes on rising edge.
REQ-004 Port: i_reset_n  in  1  asynchronous active-low reset.
REQ-005 Ports, requester A (x=a) and B (x=b):
- i_x_request  in  1  access request; held until o_x_ready.
- i_x_rw  in  1  0=read, 1=write.
- i_x_address  in  32  byte address.
- i_x_wdata  in  WIDTH  write data.
- o_x_rdata  out  WIDTH  read data.
- o_x_ready  out  1  one-cycle completion pulse.
- o_x_valid  out  1  address-in-range flag returned by memory.
REQ-006 Ports, memory side:
- o_bram_request  out  1  memory access request.
- o_bram_rw  out  1  granted direction.
- o_bram_address  out  32  granted address.
- o_bram_wdata  out  WIDTH  granted write data.
- i_bram_rdata  in  WIDTH  memory read data.
- i_bram_ready  in  1  memory completion; asserted the cycle after each cycle o_bram_request is high.
- i_bram_valid  in  1  memory range flag.

Function
REQ-007 FSM states IDLE, ACCESS, RELEASE; reset state IDLE.
REQ-008 IDLE, no request pending: stay IDLE; o_bram_request=0.
REQ-009 IDLE, any request pending: register grant (A or B per REQ-015/REQ-016) and registered copies of the granted rw/address/wdata; next state ACCESS; o_bram_request=1 from next cycle.
REQ-010 ACCESS: o_bram_request=1; o_bram_rw, o_bram_address and o_bram_wdata come from the registered copies, never directly from live requester inputs.
REQ-011 ACCESS with i_bram_ready=1 at the edge:
- clear o_bram_request;
- pulse granted o_x_ready for exactly one cycle;
- load o_x_valid from i_bram_valid;
- load o_x_rdata from i_bram_rdata on reads only;
- next state RELEASE.
REQ-012 RELEASE: o_bram_request=0; trailing i_bram_ready ignored; return to IDLE once granted i_x_request=0, otherwise stay.
REQ-013 Latency: request sampled in IDLE at edge N gives o_x_ready high in cycle N+3; minimum spacing between grants is 4 cycles.
REQ-014 Ungranted port: o_x_ready=0 and o_x_rdata/o_x_valid hold their values.
REQ-015 Default arbitration is 2-way round-robin. Pointer starts at A; after each grant the pointer points to the other port. When both request in IDLE, grant the pointer port.
REQ-016 A single requester is always granted regardless of the pointer.
REQ-017 Requester deasserting during ACCESS (protocol violation): the access still completes and ready still pulses; the FSM then leaves RELEASE on the next cycle.
REQ-018 Never more than one o_x_ready high in any cycle.

Reset
REQ-019 Reset asserted, including mid-access: state IDLE, pointer A, and all outputs 0 (o_x_rdata, o_x_ready, o_x_valid, o_bram_*) immediately and asynchronously.
REQ-020 First grant is possible on the first edge after reset deassertion.

Configuration
REQ-021 Macro BRAM_ARBITER_FIXED_PRIORITY_EN defined: port A always wins simultaneous requests, the round-robin pointer is not implemented, and starvation of B is permitted.
REQ-022 Macro undefined: round-robin per REQ-015.

Structure
REQ-023 Package bram_arbiter_pkg holds the FSM state enum (IDLE, ACCESS, RELEASE) and a port-select typedef (PORT_A, PORT_B).
REQ-024 One sub-module rr_grant2 computes the grant from both requests and the pointer. It is instantiated only without BRAM_ARBITER_FIXED_PRIORITY_EN.

Verification
REQ-025 A reads 0x10 alone, memory returns 0xDEADBEEF/valid=1 -> o_a_ready at N+3, o_a_rdata=0xDEADBEEF, o_a_valid=1, B outputs unchanged.
REQ-026 A and B request simultaneously from reset, both held -> grants A then B then A, ready cycles exactly 4 apart.
REQ-027 Same as REQ-026 with BRAM_ARBITER_FIXED_PRIORITY_EN, A re-requesting immediately after release -> B never granted while A requests.
REQ-028 B writes 0x55AA55AA to 0x20 -> o_bram_rw=1, o_bram_wdata=0x55AA55AA; o_b_rdata unchanged; trailing i_bram_ready produces no second pulse.
REQ-029 i_reset_n pulsed low during ACCESS -> all outputs 0 at once; state IDLE; next request is granted to A and completes normally.
REQ-030 A holds request 5 cycles after ready, then drops -> FSM stays RELEASE until the drop; exactly one o_a_ready pulse.
